// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: debounced submit key, code compare, timed RGB phases, lockout.
// Optional macro CODE_PROGRAM_EN: a program key stores a new code while unlocked.
module code_lock_deb #(
   parameter int unsigned DEB_CYCLES = 262144
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);
   localparam int unsigned CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

   logic s1_q, s2_q, prev_q;
   logic acc_q, acc_d;
   logic press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (s2_q != prev_q) cnt_d = '0;
      else if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
      acc_d   = (cnt_d == CMAX) ? s2_q : acc_q;
      press_d = acc_q & ~acc_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         prev_q  <= 1'b1;
         acc_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= key_n;
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
endmodule

module code_lock_ctrl #(
   parameter int unsigned       CODE_W       = 8,
   parameter logic [CODE_W-1:0] CODE_DEFAULT = 8'hAF,
   parameter int unsigned       MAX_TRIES    = 3,
   parameter int unsigned       DEB_CYCLES   = 262144,
   parameter int unsigned       HOLD_CYCLES  = 12000000,
   parameter int unsigned       LOCK_CYCLES  = 60000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_submit_n,
   input  logic              key_prog_n,
   input  logic [CODE_W-1:0] code_in,
   output logic              led_r,
   output logic              led_g,
   output logic              led_b,
   output logic              unlocked,
   output logic              locked_out,
   output logic [3:0]        fail_cnt
);
   localparam int unsigned TMAX =
      (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
   localparam int unsigned TW = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_END = TW'(LOCK_CYCLES - 1);
   localparam logic [3:0]    MAX_T    = 4'(MAX_TRIES);

   typedef enum logic [1:0] {
      S_IDLE, S_UNLOCK, S_FAIL, S_LOCKOUT
   } state_t;

   state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0] fail_q, fail_d;
   logic [CODE_W-1:0] code_q;
   logic sub_p, prog_p;
   logic led_r_q, led_g_q, led_b_q, unl_q, lo_q;

   code_lock_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sub (
      .clk(clk), .rst(rst), .key_n(key_submit_n), .press(sub_p)
   );

`ifdef CODE_PROGRAM_EN
   logic [CODE_W-1:0] code_d;

   code_lock_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prog (
      .clk(clk), .rst(rst), .key_n(key_prog_n), .press(prog_p)
   );
`else
   logic unused_prog;
   assign unused_prog = key_prog_n;
   assign prog_p = 1'b0;
   assign code_q = CODE_DEFAULT;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      fail_d  = fail_q;
`ifdef CODE_PROGRAM_EN
      code_d  = code_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (sub_p) begin
               timer_d = '0;
               if (code_in == code_q) begin
                  state_d = S_UNLOCK;
                  fail_d  = '0;
               end else if (fail_q + 4'd1 == MAX_T) begin
                  state_d = S_LOCKOUT;
                  fail_d  = MAX_T;
               end else begin
                  state_d = S_FAIL;
                  fail_d  = fail_q + 4'd1;
               end
            end
         end
         S_UNLOCK: begin
            timer_d = timer_q + 1'b1;
            // programming takes priority over the phase ending
            if (prog_p) begin
               timer_d = '0;
`ifdef CODE_PROGRAM_EN
               code_d  = code_in;
`endif
            end else if (timer_q == HOLD_END) begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
         S_FAIL: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == HOLD_END) begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
         S_LOCKOUT: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == LOCK_END) begin
               state_d = S_IDLE;
               timer_d = '0;
               fail_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         fail_q  <= '0;
`ifdef CODE_PROGRAM_EN
         code_q  <= CODE_DEFAULT;
`endif
         led_r_q <= 1'b1;
         led_g_q <= 1'b1;
         led_b_q <= 1'b1;
         unl_q   <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         fail_q  <= fail_d;
`ifdef CODE_PROGRAM_EN
         code_q  <= code_d;
`endif
         led_r_q <= (state_d != S_FAIL);
         led_g_q <= (state_d != S_UNLOCK);
         led_b_q <= (state_d != S_LOCKOUT);
         unl_q   <= (state_d == S_UNLOCK);
         lo_q    <= (state_d == S_LOCKOUT);
      end
   end

   assign led_r      = led_r_q;
   assign led_g      = led_g_q;
   assign led_b      = led_b_q;
   assign unlocked   = unl_q;
   assign locked_out = lo_q;
   assign fail_cnt   = fail_q;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: vector table plus hand sequences for code_lock_ctrl.
// Phase expectations are queued at key press and checked cycle by cycle.
module tb_code_lock_ctrl;
   localparam int HOLD = 8;
   localparam int LOCK = 20;
   localparam int GAP  = 8;
   localparam logic [4:0] IDLE_L = 5'b11100;
   localparam logic [4:0] UNL_L  = 5'b10110;
   localparam logic [4:0] FAIL_L = 5'b01100;
   localparam logic [4:0] LOCK_L = 5'b11001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_submit_n = 1'b1;
   logic key_prog_n = 1'b1;
   logic [7:0] code_in = 8'h00;
   logic led_r, led_g, led_b, unlocked, locked_out;
   logic [3:0] fail_cnt;

   int errors = 0;
   int checks = 0;
   int fc_now = 0;

   typedef enum {PH_UNL, PH_FAIL, PH_LOCK} ph_t;
   typedef struct {
      logic [7:0] code;
      ph_t        ph;
      int         fc;
      int         inj;
   } vec_t;
   typedef struct {
      logic [4:0] leds;
      int         fc;
      int         dur;
      int         fc_after;
   } exp_t;

   exp_t sb[$];
   vec_t v[8];

   always #5 clk = ~clk;

   code_lock_ctrl #(
      .CODE_W(8), .CODE_DEFAULT(8'hAF), .MAX_TRIES(3),
      .DEB_CYCLES(4), .HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCK)
   ) dut (
      .clk(clk), .rst(rst),
      .key_submit_n(key_submit_n), .key_prog_n(key_prog_n),
      .code_in(code_in),
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .unlocked(unlocked), .locked_out(locked_out),
      .fail_cnt(fail_cnt)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [4:0] el, input int efc);
      logic [4:0] act;
      act = {led_r, led_g, led_b, unlocked, locked_out};
      checks++;
      if (act !== el || fail_cnt !== 4'(efc)) begin
         errors++;
         $display("FAIL %s: got rgb_u_l=%b fail_cnt=%0d, want rgb_u_l=%b fail_cnt=%0d",
                  name, act, fail_cnt, el, efc);
      end
   endtask

   function automatic exp_t mk(input ph_t ph, input int fc);
      exp_t e;
      e.fc = fc;
      e.fc_after = fc;
      e.dur = HOLD;
      case (ph)
         PH_UNL:  e.leds = UNL_L;
         PH_FAIL: e.leds = FAIL_L;
         default: begin
            e.leds = LOCK_L;
            e.dur = LOCK;
            e.fc_after = 0;
         end
      endcase
      return e;
   endfunction

   task automatic idle_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         cmp(name, IDLE_L, fc_now);
         step;
      end
   endtask

   // key low, expectation queued; outputs must still be idle one cycle early
   task automatic press(input logic [7:0] code, input exp_t e);
      code_in = code;
      key_submit_n = 1'b0;
      sb.push_back(e);
      repeat (6) step;
      cmp("latency", IDLE_L, fc_now);
      step;
      key_submit_n = 1'b1;
   endtask

   task automatic check_phase(input string name, input int inj);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got empty scoreboard, want queued phase", name);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < e.dur; i++) begin
         cmp(name, e.leds, e.fc);
         if (inj == 1 && i == 8) begin
            code_in = 8'hAF;
            key_submit_n = 1'b0;
         end
         if (inj == 1 && i == 14) key_submit_n = 1'b1;
         if (inj == 2 && i == 0) begin
            code_in = 8'h5C;
            key_prog_n = 1'b0;
         end
         if (inj == 2 && i == 7) key_prog_n = 1'b1;
         step;
      end
      fc_now = e.fc_after;
      idle_cycles({name, "_idle"}, GAP);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      v[0] = '{8'hAF, PH_UNL,  0, 0};
      v[1] = '{8'h12, PH_FAIL, 1, 0};
      v[2] = '{8'hAF, PH_UNL,  0, 0};
      v[3] = '{8'h00, PH_FAIL, 1, 0};
      v[4] = '{8'h00, PH_FAIL, 2, 0};
      v[5] = '{8'h00, PH_LOCK, 3, 1};
      v[6] = '{8'h55, PH_FAIL, 1, 0};
      v[7] = '{8'hAF, PH_UNL,  0, 0};

      step;
      step;
      cmp("reset", IDLE_L, 0);
      rst = 1'b1;
      idle_cycles("post_reset", GAP);

      // bounce: glitches shorter than the debounce window are ignored
      for (int k = 0; k < 3; k++) begin
         key_submit_n = 1'b0;
         step;
         step;
         key_submit_n = 1'b1;
         step;
         step;
      end
      press(8'hAF, mk(PH_UNL, 0));
      check_phase("bounce", 0);

      for (int i = 0; i < 8; i++) begin
         press(v[i].code, mk(v[i].ph, v[i].fc));
         check_phase($sformatf("vec%0d", i), v[i].inj);
      end

      // reset in the middle of a lockout
      press(8'h12, mk(PH_FAIL, 1));
      check_phase("pre_lock1", 0);
      press(8'h12, mk(PH_FAIL, 2));
      check_phase("pre_lock2", 0);
      press(8'h12, mk(PH_LOCK, 3));
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         cmp("lock_before_reset", e.leds, e.fc);
         step;
      end
      rst = 1'b0;
      #1;
      cmp("reset_async", IDLE_L, 0);
      step;
      rst = 1'b1;
      fc_now = 0;
      idle_cycles("after_reset", GAP);
      press(8'hAF, mk(PH_UNL, 0));
      check_phase("unlock_after_reset", 0);

`ifdef CODE_PROGRAM_EN
      e = mk(PH_UNL, 0);
      e.dur = 15;
      press(8'hAF, e);
      check_phase("prog_restart", 2);
      press(8'hAF, mk(PH_FAIL, 1));
      check_phase("old_code", 0);
      press(8'h5C, mk(PH_UNL, 0));
      check_phase("new_code", 0);
      rst = 1'b0;
      step;
      rst = 1'b1;
      idle_cycles("prog_reset", GAP);
      press(8'hAF, mk(PH_UNL, 0));
      check_phase("default_restored", 0);
`else
      press(8'hAF, mk(PH_UNL, 0));
      check_phase("prog_in_unlock", 2);
      key_prog_n = 1'b0;
      code_in = 8'h5C;
      idle_cycles("prog_in_idle", 10);
      key_prog_n = 1'b1;
      idle_cycles("prog_release", GAP);
      press(8'h5C, mk(PH_FAIL, 1));
      check_phase("no_new_code", 0);
      press(8'hAF, mk(PH_UNL, 0));
      check_phase("default_kept", 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
